// File: rtl/exec_sequencer.sv
// exec_sequencer: owns the PC, fetches 16-bit instructions over a req/ack
// handshake and hands each one to control_unit with run held high.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, start_addr     - begin execution at start_addr (ignored when busy)
//   stop                  - halt at the next instruction boundary
//   imem_req, imem_addr   - fetch request and address (address == pc)
//   imem_ack, imem_data   - fetch accept, instruction word valid with ack
//   run, d_in             - core enable and latched instruction register
//   done                  - core STORE cycle marker
//   branch_taken/_target  - redirect, sampled only with done
//   pc, busy              - program counter, high outside IDLE
//   timeout               - sticky watchdog error flag
//   inst_count            - saturating retired-instruction count
module exec_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int MAX_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              stop,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_data,
   output logic              run,
   output logic [15:0]       d_in,
   input  logic              done,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              timeout,
   output logic [15:0]       inst_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   localparam logic [7:0] WD_LAST = 8'(MAX_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_nxt;
   logic [15:0]       ir_q;
   logic [15:0]       ir_nxt;
   logic              timeout_q;
   logic              timeout_nxt;
   logic [15:0]       count_q;
   logic [15:0]       count_nxt;
   logic              stop_pending;
   logic              stop_pending_nxt;
   logic [7:0]        wd_cnt;
   logic [7:0]        wd_cnt_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath registers, all loaded from the next-value logic below
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= '0;
         ir_q         <= '0;
         timeout_q    <= 1'b0;
         count_q      <= '0;
         stop_pending <= 1'b0;
         wd_cnt       <= '0;
      end else begin
         pc_q         <= pc_nxt;
         ir_q         <= ir_nxt;
         timeout_q    <= timeout_nxt;
         count_q      <= count_nxt;
         stop_pending <= stop_pending_nxt;
         wd_cnt       <= wd_cnt_nxt;
      end
   end

   // Next-state and next-value logic
   always_comb begin
      state_nxt        = state;
      pc_nxt           = pc_q;
      ir_nxt           = ir_q;
      timeout_nxt      = timeout_q;
      count_nxt        = count_q;
      stop_pending_nxt = stop_pending;
      wd_cnt_nxt       = wd_cnt;

      unique case (state)
         IDLE: begin
            // stop is dropped here; start wins a same-cycle collision
            if (start) begin
               pc_nxt           = start_addr;
               timeout_nxt      = 1'b0;
               count_nxt        = '0;
               stop_pending_nxt = 1'b0;
               state_nxt        = FETCH;
            end
         end

         FETCH: begin
            if (stop) begin
               stop_pending_nxt = 1'b1;
            end
            // A started fetch always runs to completion
            if (imem_ack) begin
               ir_nxt     = imem_data;
               wd_cnt_nxt = '0;
               state_nxt  = EXEC;
            end
         end

         EXEC: begin
            wd_cnt_nxt = wd_cnt + 8'd1;
            if (stop) begin
               stop_pending_nxt = 1'b1;
            end
            if (done) begin
               if (branch_taken) begin
                  pc_nxt = branch_target;
               end else begin
                  pc_nxt = pc_q + ADDR_W'(1);
               end
               if (count_q != 16'hFFFF) begin
                  count_nxt = count_q + 16'd1;
               end
               if (stop_pending || stop) begin
                  stop_pending_nxt = 1'b0;
                  state_nxt        = IDLE;
               end else begin
                  state_nxt = FETCH;
               end
            end else if (wd_cnt == WD_LAST) begin
               // Core hung: abandon the instruction, keep pc on it
               timeout_nxt      = 1'b1;
               stop_pending_nxt = 1'b0;
               state_nxt        = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs come only from registers or a state decode
   assign imem_req   = (state == FETCH);
   assign run        = (state == EXEC);
   assign busy       = (state != IDLE);
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign d_in       = ir_q;
   assign timeout    = timeout_q;
   assign inst_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed bench for exec_sequencer with a memory
// responder, a 4-cycle core model and a fetch-address scoreboard.
module tb_exec_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  start_addr;
   logic        stop;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        run;
   logic [15:0] d_in;
   logic        done;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic [7:0]  pc;
   logic        busy;
   logic        timeout;
   logic [15:0] inst_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Responder knobs, written only by the main sequence
   int         ack_delay = 0;
   bit         done_en   = 1'b1;
   bit         br_en     = 1'b0;
   bit         br_glitch = 1'b0;
   logic [7:0] br_tgt    = 8'h00;

   // Scoreboard: expected fetch addresses vs. addresses seen on ack
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int         sb_rd = 0;

   exec_sequencer #(.ADDR_W(8), .MAX_CYCLES(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .start_addr    (start_addr),
      .stop          (stop),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .run           (run),
      .d_in          (d_in),
      .done          (done),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc            (pc),
      .busy          (busy),
      .timeout       (timeout),
      .inst_count    (inst_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [7:0] a);
      return {a ^ 8'h5A, a};
   endfunction

   // Memory: ack after ack_delay wait cycles, data valid with ack
   initial begin
      int cnt;
      cnt = 0;
      imem_ack  = 1'b0;
      imem_data = 16'h0000;
      forever begin
         @(posedge clk);
         #2;
         if (imem_req === 1'b1) begin
            if (cnt == ack_delay) begin
               imem_ack  = 1'b1;
               imem_data = mem_word(imem_addr);
               obs_q.push_back(imem_addr);
               cnt = 0;
            end else begin
               imem_ack = 1'b0;
               cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   // Core: done in the 4th run cycle; optional branch_taken glitches
   initial begin
      int rc;
      rc = 0;
      done          = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         if (run === 1'b1) begin
            rc++;
            done          = (rc == 4) && done_en;
            branch_taken  = done ? br_en : br_glitch;
            branch_target = br_tgt;
            if (done) rc = 0;
         end else begin
            rc = 0;
            done         = 1'b0;
            branch_taken = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] a, input logic s);
      start      = 1'b1;
      start_addr = a;
      stop       = s;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic sb_check();
      while (sb_rd < exp_q.size()) begin
         if (sb_rd < obs_q.size()) begin
            chk("sb_fetch_addr", {24'h0, obs_q[sb_rd]},
                {24'h0, exp_q[sb_rd]});
         end else begin
            chk("sb_missing_fetch", 32'(obs_q.size()), 32'(exp_q.size()));
         end
         sb_rd++;
      end
      chk("sb_extra_fetch", 32'(obs_q.size()), 32'(exp_q.size()));
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      start_addr = 8'h00;
      stop       = 1'b0;
      tick();
      tick();
      chk("rst_pc", {24'h0, pc}, 32'h0);
      chk("rst_d_in", {16'h0, d_in}, 32'h0);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_run", {31'h0, run}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_timeout", {31'h0, timeout}, 32'h0);
      chk("rst_count", {16'h0, inst_count}, 32'h0);
      reset = 1'b0;
      tick();

      // Linear run of 3 instructions from 0x10, stop in the 3rd EXEC
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h12);
      do_start(8'h10, 1'b0);
      for (int k = 0; k < 15; k++) begin
         chk("lin_run", {31'h0, run}, {31'h0, (k % 5) != 0});
         chk("lin_req", {31'h0, imem_req}, {31'h0, (k % 5) == 0});
         if (k % 5 == 1) begin
            chk("lin_d_in", {16'h0, d_in},
                {16'h0, mem_word(8'(8'h10 + k / 5))});
         end
         stop = (k == 12);
         tick();
      end
      stop = 1'b0;
      chk("lin_busy_end", {31'h0, busy}, 32'h0);
      chk("lin_pc_end", {24'h0, pc}, 32'h13);
      chk("lin_count_end", {16'h0, inst_count}, 32'd3);
      sb_check();

      // Memory wait states: ack on the 4th FETCH cycle
      ack_delay = 3;
      exp_q.push_back(8'h30);
      do_start(8'h30, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            chk("ws_req", {31'h0, imem_req}, 32'h1);
            chk("ws_addr", {24'h0, imem_addr}, 32'h30);
            chk("ws_run", {31'h0, run}, 32'h0);
            chk("ws_d_in_hold", {16'h0, d_in}, {16'h0, mem_word(8'h12)});
         end else begin
            chk("ws_run_exec", {31'h0, run}, 32'h1);
            chk("ws_d_in", {16'h0, d_in}, {16'h0, mem_word(8'h30)});
         end
         stop = (k == 1);
         tick();
      end
      stop = 1'b0;
      ack_delay = 0;
      chk("ws_busy_end", {31'h0, busy}, 32'h0);
      chk("ws_pc_end", {24'h0, pc}, 32'h31);
      chk("ws_count_end", {16'h0, inst_count}, 32'd1);
      sb_check();

      // Branch 0x20 -> 0x05, then branch_taken glitches without done
      br_en  = 1'b1;
      br_tgt = 8'h05;
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h05);
      do_start(8'h20, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 5) begin
            chk("br_addr", {24'h0, imem_addr}, 32'h05);
            br_en     = 1'b0;
            br_glitch = 1'b1;
            br_tgt    = 8'h40;
         end
         stop = (k == 7);
         tick();
      end
      stop      = 1'b0;
      br_glitch = 1'b0;
      chk("br_busy_end", {31'h0, busy}, 32'h0);
      chk("br_glitch_pc", {24'h0, pc}, 32'h06);
      sb_check();

      // PC wrap 0xFF -> 0x00, with a start while busy
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      do_start(8'hFF, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 3) chk("busy_start_pc", {24'h0, pc}, 32'hFF);
         if (k == 5) chk("wrap_addr", {24'h0, imem_addr}, 32'h00);
         start      = (k == 2);
         start_addr = 8'h77;
         stop       = (k == 7);
         tick();
      end
      start = 1'b0;
      stop  = 1'b0;
      chk("wrap_pc_end", {24'h0, pc}, 32'h01);
      chk("wrap_count_end", {16'h0, inst_count}, 32'd2);
      sb_check();

      // start and stop together: start wins, stop dropped
      exp_q.push_back(8'h40);
      exp_q.push_back(8'h41);
      do_start(8'h40, 1'b1);
      for (int k = 0; k < 10; k++) begin
         if (k == 0) chk("ss_busy", {31'h0, busy}, 32'h1);
         if (k == 5) chk("ss_continue", {31'h0, imem_req}, 32'h1);
         stop = (k == 6);
         tick();
      end
      stop = 1'b0;
      chk("ss_pc_end", {24'h0, pc}, 32'h42);
      chk("ss_count_end", {16'h0, inst_count}, 32'd2);
      sb_check();

      // Watchdog: done stuck low
      done_en = 1'b0;
      exp_q.push_back(8'h50);
      do_start(8'h50, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 8) begin
            chk("wd_pre_timeout", {31'h0, timeout}, 32'h0);
            chk("wd_pre_run", {31'h0, run}, 32'h1);
         end
         if (k == 9) begin
            chk("wd_timeout", {31'h0, timeout}, 32'h1);
            chk("wd_idle", {31'h0, busy}, 32'h0);
            chk("wd_pc", {24'h0, pc}, 32'h50);
         end
         tick();
      end
      done_en = 1'b1;
      exp_q.push_back(8'h60);
      do_start(8'h60, 1'b0);
      chk("wd_clear", {31'h0, timeout}, 32'h0);
      for (int k = 0; k < 5; k++) begin
         stop = (k == 2);
         tick();
      end
      stop = 1'b0;
      chk("wd_after_count", {16'h0, inst_count}, 32'd1);
      sb_check();

      // Reset in the 2nd EXEC cycle
      exp_q.push_back(8'h70);
      do_start(8'h70, 1'b0);
      tick();
      tick();
      chk("mr_in_exec", {31'h0, run}, 32'h1);
      reset = 1'b1;
      tick();
      chk("mr_run", {31'h0, run}, 32'h0);
      chk("mr_busy", {31'h0, busy}, 32'h0);
      chk("mr_pc", {24'h0, pc}, 32'h0);
      chk("mr_count", {16'h0, inst_count}, 32'h0);
      chk("mr_d_in", {16'h0, d_in}, 32'h0);
      chk("mr_req", {31'h0, imem_req}, 32'h0);
      reset = 1'b0;
      tick();
      tick();
      sb_check();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Instruction sequencer for the bitty core. It owns the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and presents each instruction to `control_unit` on `d_in` with `run` held high. It waits for the core's `done`, then advances the PC or takes a branch, and handles start/stop requests and a watchdog timeout. It sits between the top level / instruction memory and `control_unit`.

## Interface
- `ADDR_W`, 8: instruction address width; the PC wraps modulo 2^ADDR_W.
- `MAX_CYCLES`, 8: EXEC-state watchdog limit in cycles; legal range 5..255.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; also drives the core's `reset`.
- `start` in 1: single-cycle request to begin execution at `start_addr`.
- `start_addr` in ADDR_W: first fetch address, sampled with `start`.
- `stop` in 1: single-cycle request to halt at the next instruction boundary.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address; always equal to `pc`.
- `imem_ack` in 1: memory accepts the request; `imem_data` is valid in the same cycle.
- `imem_data` in 16: instruction word.
- `run` out 1: goes to the core's `run`.
- `d_in` out 16: latched instruction register; goes to the core's `d_in`.
- `done` in 1: from the core; high in the core's STORE cycle.
- `branch_taken` in 1: redirect request, sampled only in the cycle where `done` is high.
- `branch_target` in ADDR_W: redirect address, sampled with `branch_taken`.
- `pc` out ADDR_W: current program counter.
- `busy` out 1: high in every state except IDLE.
- `timeout` out 1: sticky watchdog error flag.
- `inst_count` out 16: count of retired instructions; saturates at 0xFFFF.

## Operation
- States: IDLE, FETCH, EXEC. All outputs are registered or decoded only from state; there is no combinational path from inputs to outputs.
- Reset values: state IDLE, `pc` 0, `d_in` 0, `imem_req` 0, `run` 0, `busy` 0, `timeout` 0, `inst_count` 0, `stop_pending` 0, `wd_cnt` 0.
- IDLE
  - When `start` = 1: `pc` <= `start_addr`, `timeout` <= 0, `inst_count` <= 0, `stop_pending` <= 0, next state FETCH.
  - `stop` is ignored in IDLE.
- FETCH
  - `imem_req` = 1 and `imem_addr` = `pc`. Both stay stable until `imem_ack` is high; there is no timeout in FETCH.
  - When `imem_ack` = 1: `d_in` <= `imem_data`, `wd_cnt` <= 0, next state EXEC.
- EXEC
  - `run` = 1 and `d_in` is held constant. `wd_cnt` increments every cycle.
  - When `done` = 1:
    - `pc` <= `branch_target` if `branch_taken`, otherwise `pc`+1 (wraps from 2^ADDR_W−1 to 0).
    - `inst_count` increments, saturating at 0xFFFF.
    - Next state is IDLE if `stop_pending` or `stop` is high this cycle (and `stop_pending` clears); otherwise FETCH.
  - When `done` = 0 and `wd_cnt` = MAX_CYCLES−1: `timeout` <= 1, `pc` is unchanged, `stop_pending` <= 0, next state IDLE.
- `stop` in FETCH or EXEC sets `stop_pending`. An instruction already in fetch is always completed and executed, never abandoned.
- `start` while busy is ignored.
- `start` and `stop` in the same IDLE cycle: start is accepted, stop is dropped.
- `done` outside EXEC is ignored. `branch_taken` without `done` is ignored.

## Timing
- Fetch latency: 1 cycle minimum when `imem_ack` is high in the first FETCH cycle; extends by one cycle per cycle of ack wait.
- The core needs 4 `run` cycles (INITIAL, LOAD, CALCULATE, STORE), with `done` in the 4th. `run` is still high on the done cycle, so the core returns to INITIAL on the same edge that this block leaves EXEC.
- Steady-state throughput with zero-wait memory: one instruction every 5 cycles (1 FETCH + 4 EXEC).
- `run` falls in the cycle after `done`. `imem_req` rises in that same cycle when continuing.
- `busy` rises in the cycle after `start` and falls in the cycle after the final `done` or after the timeout.
- Reset mid-operation: on the next edge every output takes its reset value. This includes `run` 0 and `imem_req` 0, even in the middle of a handshake.
- Watchdog: with `done` stuck low, `timeout` rises exactly MAX_CYCLES cycles after EXEC entry.

## Test plan
- Linear run, zero-wait memory, `start_addr` = 0x10 with 3 instructions, then `stop` during the 3rd EXEC:
  - `imem_addr` sequence is 0x10, 0x11, 0x12.
  - `run` high for 4 cycles per instruction, 5-cycle period.
  - Ends in IDLE with `pc` = 0x13 and `inst_count` = 3.
- Memory wait states: `imem_ack` delayed 3 cycles:
  - `imem_req` and `imem_addr` stay stable for 4 cycles.
  - `d_in` loads only on the ack cycle.
  - `run` stays low during the wait.
- Branch: `done` with `branch_taken` = 1 and `branch_target` = 0x05 at `pc` = 0x20 → next `imem_addr` = 0x05. A `branch_taken` pulse without `done` has no effect.
- Wrap and boundaries:
  - `pc` = 0xFF with no branch → next fetch at 0x00.
  - `start` + `stop` in the same IDLE cycle → execution begins.
  - `start` while busy → ignored.
- Watchdog: core `done` held low → `timeout` = 1 after 8 EXEC cycles, state IDLE, `pc` unchanged. A following `start` clears `timeout`.
- Reset asserted in the 2nd EXEC cycle → next cycle `run` = 0, `busy` = 0, `pc` = 0, `inst_count` = 0, `d_in` = 0.
